// File: rtl/rv32_pipe_ctrl.sv
// Hazard and sequencing controller for the 5-stage RV32 pipeline.
// Produces stall/flush/bubble controls for PC and the four pipeline queues,
// handles load-use, taken-branch redirect, data-memory waits and halt/drain.
// Optional performance counters are built when PIPE_CTRL_PERF_EN is defined.
module rv32_pipe_ctrl #(
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter int unsigned MEM_TIMEOUT  = 15,
  parameter int unsigned CNT_W        = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_uses_rs1,
  input  logic        id_uses_rs2,
  input  logic        id_hlt,
  input  logic [4:0]  ex_rd,
  input  logic        ex_is_load,
  input  logic        ex_branch_taken,
  input  logic        mem_req,
  input  logic        mem_ack,
  input  logic        resume,
  output logic        pc_stall,
  output logic        ifid_stall,
  output logic        ifid_flush,
  output logic        idex_stall,
  output logic        idex_bubble,
  output logic        exmem_stall,
  output logic        memwb_bubble,
  output logic        halted,
  output logic        mem_err,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
);

  typedef enum logic [1:0] {StRun, StMemWait, StDrain, StHalted} state_e;

  state_e           state_q, state_d;
  logic             ret_drain_q, ret_drain_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] drain_cnt_q, drain_cnt_d;
  logic             mem_err_q, mem_err_d;

  logic lu_hazard;
  logic mem_miss;
  logic stall_set;
  logic pc_s, ifid_s, ifid_f, idex_b;

  assign lu_hazard = ex_is_load & (ex_rd != 5'd0) &
                     ((id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd)));
  assign mem_miss  = mem_req & ~mem_ack;

  // Next-state and raw control decode per FSM state.
  always_comb begin
    state_d     = state_q;
    ret_drain_d = ret_drain_q;
    wait_cnt_d  = wait_cnt_q;
    drain_cnt_d = drain_cnt_q;
    mem_err_d   = mem_err_q;
    stall_set   = 1'b0;
    pc_s        = 1'b0;
    ifid_s      = 1'b0;
    ifid_f      = 1'b0;
    idex_b      = 1'b0;

    unique case (state_q)
      StRun: begin
        if (mem_miss) begin
          stall_set   = 1'b1;
          state_d     = StMemWait;
          wait_cnt_d  = CNT_W'(1);
          ret_drain_d = 1'b0;
        end else if (ex_branch_taken) begin
          ifid_f = 1'b1;
          idex_b = 1'b1;
        end else if (lu_hazard) begin
          pc_s   = 1'b1;
          ifid_s = 1'b1;
          idex_b = 1'b1;
        end else if (id_hlt) begin
          // The halt itself moves on into ID/EX; only younger fetches are killed.
          pc_s        = 1'b1;
          ifid_f      = 1'b1;
          state_d     = StDrain;
          drain_cnt_d = CNT_W'(DRAIN_CYCLES - 1);
        end
      end
      StMemWait: begin
        if (!mem_ack) begin
          stall_set = 1'b1;
          if (wait_cnt_q == CNT_W'(MEM_TIMEOUT)) begin
            mem_err_d = 1'b1;
            state_d   = StHalted;
          end else begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
          end
        end else begin
          state_d = ret_drain_q ? StDrain : StRun;
          if (ret_drain_q) begin
            pc_s   = 1'b1;
            ifid_f = 1'b1;
          end
        end
      end
      StDrain: begin
        pc_s   = 1'b1;
        ifid_f = 1'b1;
        if (mem_miss) begin
          stall_set   = 1'b1;
          state_d     = StMemWait;
          wait_cnt_d  = CNT_W'(1);
          ret_drain_d = 1'b1;
        end else if (drain_cnt_q == '0) begin
          state_d = StHalted;
        end else begin
          drain_cnt_d = drain_cnt_q - CNT_W'(1);
        end
      end
      StHalted: begin
        stall_set = 1'b1;
        if (resume) begin
          state_d = StRun;
          ifid_f  = 1'b1;
        end
      end
      default: state_d = StRun;
    endcase
  end

  // Output resolution: flush/bubble beats stall on the same queue; reset forces all low.
  always_comb begin
    pc_stall     = ~rst & (pc_s | stall_set);
    ifid_flush   = ~rst & ifid_f;
    ifid_stall   = ~rst & (ifid_s | stall_set) & ~ifid_f;
    idex_bubble  = ~rst & idex_b;
    idex_stall   = ~rst & stall_set & ~idex_b;
    exmem_stall  = ~rst & stall_set;
    memwb_bubble = ~rst & stall_set;
    halted       = ~rst & (state_q == StHalted);
    mem_err      = ~rst & mem_err_q;
  end

  // Controller state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StRun;
      ret_drain_q <= 1'b0;
      wait_cnt_q  <= '0;
      drain_cnt_q <= '0;
      mem_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ret_drain_q <= ret_drain_d;
      wait_cnt_q  <= wait_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      mem_err_q   <= mem_err_d;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_flush_q, perf_flush_d;

  // Stall cycles outside HALTED and flush events while running; both wrap.
  always_comb begin
    perf_stall_d = perf_stall_q;
    perf_flush_d = perf_flush_q;
    if (pc_stall && (state_q != StHalted)) perf_stall_d = perf_stall_q + 32'd1;
    if (ifid_flush && (state_q == StRun))  perf_flush_d = perf_flush_q + 32'd1;
  end

  // Performance counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign perf_stall_cnt = perf_stall_q;
  assign perf_flush_cnt = perf_flush_q;
`else
  assign perf_stall_cnt = 32'd0;
  assign perf_flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_rv32_pipe_ctrl.sv
// Scoreboard bench for rv32_pipe_ctrl: each cycle's expected control vector is
// queued when its stimulus is driven and compared on the following negedge.
module tb_rv32_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_uses_rs1, id_uses_rs2, id_hlt, ex_is_load, ex_branch_taken;
  logic        mem_req, mem_ack, resume;
  logic        pc_stall, ifid_stall, ifid_flush, idex_stall, idex_bubble;
  logic        exmem_stall, memwb_bubble, halted, mem_err;
  logic [31:0] perf_stall_cnt, perf_flush_cnt;

  rv32_pipe_ctrl #(
    .DRAIN_CYCLES (4),
    .MEM_TIMEOUT  (15),
    .CNT_W        (4)
  ) u_dut (
    .clk             (clk),
    .rst             (rst),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_uses_rs1     (id_uses_rs1),
    .id_uses_rs2     (id_uses_rs2),
    .id_hlt          (id_hlt),
    .ex_rd           (ex_rd),
    .ex_is_load      (ex_is_load),
    .ex_branch_taken (ex_branch_taken),
    .mem_req         (mem_req),
    .mem_ack         (mem_ack),
    .resume          (resume),
    .pc_stall        (pc_stall),
    .ifid_stall      (ifid_stall),
    .ifid_flush      (ifid_flush),
    .idex_stall      (idex_stall),
    .idex_bubble     (idex_bubble),
    .exmem_stall     (exmem_stall),
    .memwb_bubble    (memwb_bubble),
    .halted          (halted),
    .mem_err         (mem_err),
    .perf_stall_cnt  (perf_stall_cnt),
    .perf_flush_cnt  (perf_flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic       hlt;
    logic [4:0] rd;
    logic       ld;
    logic       br;
    logic       req;
    logic       ack;
    logic       res;
  } stim_t;

  // Output vector bits: pc_stall ifid_stall ifid_flush idex_stall idex_bubble
  // exmem_stall memwb_bubble halted mem_err
  localparam logic [31:0] PC = 32'h100, IS = 32'h080, IF = 32'h040, XS = 32'h020;
  localparam logic [31:0] XB = 32'h010, ES = 32'h008, MB = 32'h004, HL = 32'h002;
  localparam logic [31:0] ME = 32'h001;
  localparam logic [31:0] O_MEM    = PC | IS | XS | ES | MB;
  localparam logic [31:0] O_BR     = IF | XB;
  localparam logic [31:0] O_LU     = PC | IS | XB;
  localparam logic [31:0] O_HLT    = PC | IF;
  localparam logic [31:0] O_DRMEM  = PC | IF | XS | ES | MB;
  localparam logic [31:0] O_HALTED = O_MEM | HL;
  localparam logic [31:0] O_RESUME = PC | IF | XS | ES | MB | HL;

  // Expected FSM state codes, used only for the perf-counter expectations.
  localparam int S_RUN = 0, S_WAIT = 1, S_DRAIN = 2, S_HALT = 3;

  int n_tests = 0;
  int n_fail  = 0;
  int e_stall = 0;
  int e_flush = 0;

  string       tag_q[$];
  logic [31:0] exp_q[$];

  logic [31:0] obs;
  assign obs = {23'd0, pc_stall, ifid_stall, ifid_flush, idex_stall, idex_bubble,
                exmem_stall, memwb_bubble, halted, mem_err};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic stim_t f_idle();
    return '0;
  endfunction

  function automatic stim_t f_lu(input logic [4:0] rd, input logic [4:0] rs1,
                                 input logic [4:0] rs2, input logic u1, input logic u2);
    stim_t s = '0;
    s.ld = 1'b1; s.rd = rd; s.rs1 = rs1; s.rs2 = rs2; s.u1 = u1; s.u2 = u2;
    return s;
  endfunction

  function automatic stim_t f_br();
    stim_t s = '0;
    s.br = 1'b1;
    return s;
  endfunction

  function automatic stim_t f_hlt();
    stim_t s = '0;
    s.hlt = 1'b1;
    return s;
  endfunction

  function automatic stim_t f_mem(input logic req, input logic ack);
    stim_t s = '0;
    s.req = req; s.ack = ack;
    return s;
  endfunction

  function automatic stim_t f_res();
    stim_t s = '0;
    s.res = 1'b1;
    return s;
  endfunction

  task automatic drive(input stim_t s);
    id_rs1 = s.rs1; id_rs2 = s.rs2; id_uses_rs1 = s.u1; id_uses_rs2 = s.u2;
    id_hlt = s.hlt; ex_rd = s.rd; ex_is_load = s.ld; ex_branch_taken = s.br;
    mem_req = s.req; mem_ack = s.ack; resume = s.res;
  endtask

  // One cycle: drive, queue expectation, compare at negedge, advance past posedge.
  task automatic step(input string tag, input stim_t s, input logic [31:0] exp, input int st);
    string       t;
    logic [31:0] e;
    drive(s);
    tag_q.push_back(tag);
    exp_q.push_back(exp);
`ifdef PIPE_CTRL_PERF_EN
    if (exp[8] && st != S_HALT) e_stall++;
    if (exp[6] && st == S_RUN)  e_flush++;
`endif
    @(negedge clk);
    if (exp_q.size() == 0) begin
      check_eq("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      check_eq(t, obs, e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_perf(input string tag);
    check_eq({tag, "_pstall"}, perf_stall_cnt, 32'(e_stall));
    check_eq({tag, "_pflush"}, perf_flush_cnt, 32'(e_flush));
  endtask

  initial begin
    drive(f_idle());
    #3;
    check_eq("reset_out", obs, 32'd0);
    check_perf("reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    step("idle", f_idle(), 32'd0, S_RUN);

    // Load-use on rs1 and rs2, one-cycle stall each; x0 and unused source are no hazard.
    step("lu_rs1", f_lu(5'd5, 5'd5, 5'd0, 1'b1, 1'b0), O_LU, S_RUN);
    step("lu_rs1_after", f_idle(), 32'd0, S_RUN);
    step("lu_rs2", f_lu(5'd7, 5'd3, 5'd7, 1'b1, 1'b1), O_LU, S_RUN);
    step("lu_unused", f_lu(5'd9, 5'd9, 5'd9, 1'b0, 1'b0), 32'd0, S_RUN);
    step("lu_x0", f_lu(5'd0, 5'd0, 5'd0, 1'b1, 1'b1), 32'd0, S_RUN);

    // Branch beats load-use and halt.
    step("br_lu", stim_t'(f_br() | f_lu(5'd5, 5'd5, 5'd0, 1'b1, 1'b0)), O_BR, S_RUN);
    step("br_hlt", stim_t'(f_br() | f_hlt()), O_BR, S_RUN);
    step("br_no_drain", f_idle(), 32'd0, S_RUN);

    // Same-cycle ack: no stall. Then a three-cycle wait.
    step("mem_hit", f_mem(1'b1, 1'b1), 32'd0, S_RUN);
    step("mw_req", f_mem(1'b1, 1'b0), O_MEM, S_RUN);
    step("mw_wait1", f_mem(1'b1, 1'b0), O_MEM, S_WAIT);
    step("mw_wait2", stim_t'(f_mem(1'b1, 1'b0) | f_br()), O_MEM, S_WAIT);
    step("mw_ack", f_mem(1'b1, 1'b1), 32'd0, S_WAIT);
    step("mw_run", f_idle(), 32'd0, S_RUN);

    // Halt with a memory wait (request cycle + ack cycle) in the middle of the drain.
    step("hlt", f_hlt(), O_HLT, S_RUN);
    step("dr_1", f_idle(), O_HLT, S_DRAIN);
    step("dr_memreq", f_mem(1'b1, 1'b0), O_DRMEM, S_DRAIN);
    step("dr_memack", f_mem(1'b1, 1'b1), O_HLT, S_WAIT);
    step("dr_2", stim_t'(f_br() | f_hlt() | f_lu(5'd5, 5'd5, 5'd0, 1'b1, 1'b0)), O_HLT, S_DRAIN);
    step("dr_3", f_idle(), O_HLT, S_DRAIN);
    step("dr_4", f_idle(), O_HLT, S_DRAIN);
    step("halted_6", f_idle(), O_HALTED, S_HALT);
    step("halted_hold", f_hlt(), O_HALTED, S_HALT);
    step("resume", f_res(), O_RESUME, S_HALT);
    step("resume_run", f_idle(), 32'd0, S_RUN);
    step("resume_in_run", f_res(), 32'd0, S_RUN);
    check_perf("mid");

    // Timeout: 16 cycles without ack.
    step("to_req", f_mem(1'b1, 1'b0), O_MEM, S_RUN);
    for (int i = 0; i < 14; i++) step("to_wait", f_mem(1'b1, 1'b0), O_MEM, S_WAIT);
    step("to_last", f_mem(1'b1, 1'b0), O_MEM, S_WAIT);
    step("to_halted", f_idle(), O_HALTED | ME, S_HALT);
    step("to_resume", f_res(), O_RESUME | ME, S_HALT);
    step("to_err_sticky", f_idle(), ME, S_RUN);
    check_perf("pre_rst");

    // Reset in the middle of a memory wait, request still asserted.
    step("rw_req", f_mem(1'b1, 1'b0), O_MEM | ME, S_RUN);
    step("rw_wait", f_mem(1'b1, 1'b0), O_MEM | ME, S_WAIT);
    #2;
    rst = 1'b1;
    #1;
    e_stall = 0;
    e_flush = 0;
    check_eq("rst_async_out", obs, 32'd0);
    check_perf("rst_async");
    @(negedge clk);
    rst = 1'b0;
    step("post_rst_idle", f_idle(), 32'd0, S_RUN);
    step("post_rst_lu", f_lu(5'd12, 5'd1, 5'd12, 1'b0, 1'b1), O_LU, S_RUN);
    check_perf("end");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
